// File: rtl/bcp_clause_scheduler.sv
// Clause scheduler for Boolean constraint propagation: walks a window of clauses,
// issues each one to the evaluator bank and forwards unit implications or stops on conflict.
`timescale 1ns/1ps
module bcp_clause_scheduler (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [9:0]  clause_base,
    input  logic [9:0]  clause_count,
    output logic        cmem_rd_en,
    output logic [9:0]  cmem_addr,
    input  logic [54:0] cmem_rd_data,
    output logic        eval_valid,
    output logic [54:0] eval_clause,
    input  logic        eval_unit,
    input  logic        eval_conflict,
    input  logic [8:0]  eval_implied_var,
    input  logic        eval_new_value,
    output logic        imp_valid,
    output logic [8:0]  imp_var,
    output logic        imp_value,
    input  logic        imp_ready,
    output logic        busy,
    output logic        done,
    output logic        conflict,
    output logic [9:0]  conflict_clause
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EVAL,
        S_CHECK,
        S_PUSH,
        S_FINISH
    } state_t;

    state_t      r_state;
    logic [9:0]  r_base;
    logic [9:0]  r_count;
    logic [9:0]  r_offset;
    logic [9:0]  r_addr;
    logic        r_rd_en;
    logic        r_eval_valid;
    logic [54:0] r_clause;
    logic        r_imp_valid;
    logic [8:0]  r_imp_var;
    logic        r_imp_value;
    logic        r_done;
    logic        r_conflict;
    logic [9:0]  r_conflict_clause;

    logic [9:0]  w_cur_idx;
    logic [9:0]  w_next_off;
    logic [9:0]  w_next_addr;
    logic        w_more;

    // Clause indices wrap modulo 1024 through natural 10-bit overflow.
    assign w_cur_idx   = r_base + r_offset;
    assign w_next_off  = r_offset + 10'd1;
    assign w_next_addr = r_base + w_next_off;
    assign w_more      = ({1'b0, r_offset} + 11'd1) < {1'b0, r_count};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= S_IDLE;
            r_base            <= '0;
            r_count           <= '0;
            r_offset          <= '0;
            r_addr            <= '0;
            r_rd_en           <= 1'b0;
            r_eval_valid      <= 1'b0;
            r_clause          <= '0;
            r_imp_valid       <= 1'b0;
            r_imp_var         <= '0;
            r_imp_value       <= 1'b0;
            r_done            <= 1'b0;
            r_conflict        <= 1'b0;
            r_conflict_clause <= '0;
        end else begin
            r_rd_en      <= 1'b0;
            r_eval_valid <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_conflict <= 1'b0;
                        if (clause_count != 10'd0) begin
                            r_base   <= clause_base;
                            r_count  <= clause_count;
                            r_offset <= '0;
                            r_addr   <= clause_base;
                            r_rd_en  <= 1'b1;
                            r_state  <= S_FETCH;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_FETCH: begin
                    r_eval_valid <= 1'b1;
                    r_state      <= S_EVAL;
                end
                S_EVAL: begin
                    r_clause <= cmem_rd_data;
                    r_state  <= S_CHECK;
                end
                S_CHECK: begin
                    if (eval_conflict) begin
                        r_conflict        <= 1'b1;
                        r_conflict_clause <= w_cur_idx;
                        r_done            <= 1'b1;
                        r_state           <= S_FINISH;
                    end else if (eval_unit) begin
                        r_imp_var   <= eval_implied_var;
                        r_imp_value <= eval_new_value;
                        r_imp_valid <= 1'b1;
                        r_state     <= S_PUSH;
                    end else if (w_more) begin
                        r_offset <= w_next_off;
                        r_addr   <= w_next_addr;
                        r_rd_en  <= 1'b1;
                        r_state  <= S_FETCH;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end
                end
                S_PUSH: begin
                    if (imp_ready) begin
                        r_imp_valid <= 1'b0;
                        if (w_more) begin
                            r_offset <= w_next_off;
                            r_addr   <= w_next_addr;
                            r_rd_en  <= 1'b1;
                            r_state  <= S_FETCH;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The read word arrives during EVAL, so it is forwarded straight through while
    // being captured; the held copy drives the evaluators afterwards.
    assign eval_clause     = (r_state == S_EVAL) ? cmem_rd_data : r_clause;
    assign eval_valid      = r_eval_valid;
    assign cmem_rd_en      = r_rd_en;
    assign cmem_addr       = r_addr;
    assign imp_valid       = r_imp_valid;
    assign imp_var         = r_imp_var;
    assign imp_value       = r_imp_value;
    assign busy            = (r_state != S_IDLE);
    assign done            = r_done;
    assign conflict        = r_conflict;
    assign conflict_clause = r_conflict_clause;

endmodule

// File: tb/tb_bcp_clause_scheduler.sv
// Directed bench for bcp_clause_scheduler with a behavioural clause memory and
// a table-driven evaluator keyed by the address of the last read.
`timescale 1ns/1ps
module tb_bcp_clause_scheduler;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  clause_base = '0;
    logic [9:0]  clause_count = '0;
    logic        cmem_rd_en;
    logic [9:0]  cmem_addr;
    logic [54:0] cmem_rd_data = '0;
    logic        eval_valid;
    logic [54:0] eval_clause;
    logic        eval_unit = 1'b0;
    logic        eval_conflict = 1'b0;
    logic [8:0]  eval_implied_var = '0;
    logic        eval_new_value = 1'b0;
    logic        imp_valid;
    logic [8:0]  imp_var;
    logic        imp_value;
    logic        imp_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        conflict;
    logic [9:0]  conflict_clause;

    bcp_clause_scheduler dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .clause_base      (clause_base),
        .clause_count     (clause_count),
        .cmem_rd_en       (cmem_rd_en),
        .cmem_addr        (cmem_addr),
        .cmem_rd_data     (cmem_rd_data),
        .eval_valid       (eval_valid),
        .eval_clause      (eval_clause),
        .eval_unit        (eval_unit),
        .eval_conflict    (eval_conflict),
        .eval_implied_var (eval_implied_var),
        .eval_new_value   (eval_new_value),
        .imp_valid        (imp_valid),
        .imp_var          (imp_var),
        .imp_value        (imp_value),
        .imp_ready        (imp_ready),
        .busy             (busy),
        .done             (done),
        .conflict         (conflict),
        .conflict_clause  (conflict_clause)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [54:0] mem     [1024];
    bit          unit_t  [1024];
    bit          conf_t  [1024];
    logic [8:0]  var_t   [1024];
    bit          val_t   [1024];

    logic [9:0]  rd_log[$];
    logic [9:0]  last_addr = '0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          imp_cycles = 0;
    int          xfer_cnt = 0;
    logic [8:0]  xfer_var = '0;
    logic        xfer_val = 1'b0;
    int          s_cyc = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Memory and evaluator models respond at the falling edge so their outputs are
    // stable well before the DUT samples them.
    always @(negedge clock) begin
        if (cmem_rd_en) begin
            rd_log.push_back(cmem_addr);
            last_addr    = cmem_addr;
            cmem_rd_data = mem[cmem_addr];
        end
        if (eval_valid) begin
            check_val("eval_clause", 64'(eval_clause), 64'(mem[last_addr]));
            eval_unit        = unit_t[last_addr];
            eval_conflict    = conf_t[last_addr];
            eval_implied_var = var_t[last_addr];
            eval_new_value   = val_t[last_addr];
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (imp_valid) begin
            imp_cycles++;
            if (imp_ready) begin
                xfer_cnt++;
                xfer_var = imp_var;
                xfer_val = imp_value;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = {45'(i * 7919 + 13), 10'(i)};
            unit_t[i] = 1'b0;
            conf_t[i] = 1'b0;
            var_t[i]  = 9'(i * 5);
            val_t[i]  = 1'b0;
        end
        rd_log.delete();
    endtask

    task automatic start_pass(input logic [9:0] b, input logic [9:0] c);
        clause_base  = b;
        clause_count = c;
        start        = 1'b1;
        s_cyc        = cyc;
        tick();
        start        = 1'b0;
        $display("[TB] start base=%0d count=%0d at cycle %0d", b, c, s_cyc);
    endtask

    task automatic wait_done(input int d0, input string tag);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            tick();
            n++;
        end
        if (done_cnt == d0) check_val({tag, "_timeout"}, 64'(done_cnt), 64'(d0 + 1));
        tick();
        $display("[TB] %s done after %0d cycles conflict=%0d clause=%0d reads=%0d",
                 tag, done_cyc - s_cyc, conflict, conflict_clause, rd_log.size());
    endtask

    task automatic wait_imp(input string tag);
        int n;
        n = 0;
        while (!imp_valid && n < 100) begin
            tick();
            n++;
        end
        check_val({tag, "_imp_seen"}, 64'(imp_valid), 64'd1);
    endtask

    initial begin
        int d0;
        int ic0;
        int x0;
        clear_tables();
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_conflict", 64'(conflict), 64'd0);
        check_val("rst_imp_valid", 64'(imp_valid), 64'd0);
        check_val("rst_rd_en", 64'(cmem_rd_en), 64'd0);
        check_val("rst_eval_valid", 64'(eval_valid), 64'd0);
        check_val("rst_addr", 64'(cmem_addr), 64'd0);
        check_val("rst_cclause", 64'(conflict_clause), 64'd0);
        check_val("rst_imp_var", 64'(imp_var), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Two clear clauses: 3N+1 = 7 cycles.
        clear_tables();
        d0 = done_cnt;
        start_pass(10'd5, 10'd2);
        wait_done(d0, "clear2");
        check_val("clear2_reads", 64'(rd_log.size()), 64'd2);
        check_val("clear2_addr0", 64'(rd_log[0]), 64'd5);
        check_val("clear2_addr1", 64'(rd_log[1]), 64'd6);
        check_val("clear2_latency", 64'(done_cyc - s_cyc), 64'd7);
        check_val("clear2_conflict", 64'(conflict), 64'd0);
        check_val("clear2_dones", 64'(done_cnt - d0), 64'd1);
        check_val("clear2_idle", 64'(busy), 64'd0);

        // Unit clause with back-pressure.
        clear_tables();
        unit_t[40] = 1'b1;
        var_t[40]  = 9'h1A3;
        val_t[40]  = 1'b1;
        imp_ready  = 1'b0;
        d0  = done_cnt;
        ic0 = imp_cycles;
        x0  = xfer_cnt;
        start_pass(10'd40, 10'd1);
        wait_imp("unit");
        for (int k = 0; k < 4; k++) begin
            check_val("unit_hold_valid", 64'(imp_valid), 64'd1);
            check_val("unit_hold_var", 64'(imp_var), 64'h1A3);
            check_val("unit_hold_val", 64'(imp_value), 64'd1);
            tick();
        end
        imp_ready = 1'b1;
        tick();
        check_val("unit_released", 64'(imp_valid), 64'd0);
        wait_done(d0, "unit");
        check_val("unit_xfers", 64'(xfer_cnt - x0), 64'd1);
        check_val("unit_xfer_var", 64'(xfer_var), 64'h1A3);
        check_val("unit_xfer_val", 64'(xfer_val), 64'd1);
        check_val("unit_valid_cycles", 64'(imp_cycles - ic0), 64'd5);
        check_val("unit_conflict", 64'(conflict), 64'd0);
        check_val("unit_dones", 64'(done_cnt - d0), 64'd1);

        // Address wrap with a conflict on the fifth clause and a unit on the second.
        clear_tables();
        conf_t[0]    = 1'b1;
        unit_t[1021] = 1'b1;
        var_t[1021]  = 9'h055;
        val_t[1021]  = 1'b0;
        d0 = done_cnt;
        x0 = xfer_cnt;
        start_pass(10'd1020, 10'd6);
        wait_done(d0, "wrap");
        check_val("wrap_reads", 64'(rd_log.size()), 64'd5);
        check_val("wrap_addr0", 64'(rd_log[0]), 64'd1020);
        check_val("wrap_addr3", 64'(rd_log[3]), 64'd1023);
        check_val("wrap_addr4", 64'(rd_log[4]), 64'd0);
        check_val("wrap_conflict", 64'(conflict), 64'd1);
        check_val("wrap_cclause", 64'(conflict_clause), 64'd0);
        check_val("wrap_xfer", 64'(xfer_cnt - x0), 64'd1);
        check_val("wrap_xfer_var", 64'(xfer_var), 64'h055);

        // Conflict outranks unit.
        clear_tables();
        unit_t[200] = 1'b1;
        conf_t[200] = 1'b1;
        d0  = done_cnt;
        ic0 = imp_cycles;
        start_pass(10'd200, 10'd3);
        wait_done(d0, "prio");
        check_val("prio_no_imp", 64'(imp_cycles - ic0), 64'd0);
        check_val("prio_conflict", 64'(conflict), 64'd1);
        check_val("prio_cclause", 64'(conflict_clause), 64'd200);
        check_val("prio_reads", 64'(rd_log.size()), 64'd1);

        // A fresh pass clears the sticky conflict.
        clear_tables();
        d0 = done_cnt;
        start_pass(10'd300, 10'd1);
        wait_done(d0, "clr");
        check_val("clr_conflict", 64'(conflict), 64'd0);
        check_val("clr_latency", 64'(done_cyc - s_cyc), 64'd4);

        // Empty pass.
        clear_tables();
        d0 = done_cnt;
        start_pass(10'd77, 10'd0);
        wait_done(d0, "empty");
        check_val("empty_latency", 64'(done_cyc - s_cyc), 64'd1);
        check_val("empty_reads", 64'(rd_log.size()), 64'd0);

        // Start while busy is ignored.
        clear_tables();
        d0 = done_cnt;
        start_pass(10'd10, 10'd3);
        tick();
        clause_base  = 10'd500;
        clause_count = 10'd1;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        wait_done(d0, "busy");
        for (int k = 0; k < 5; k++) tick();
        check_val("busy_reads", 64'(rd_log.size()), 64'd3);
        check_val("busy_addr2", 64'(rd_log[2]), 64'd12);
        check_val("busy_latency", 64'(done_cyc - s_cyc), 64'd10);
        check_val("busy_dones", 64'(done_cnt - d0), 64'd1);

        // Reset during PUSH.
        clear_tables();
        unit_t[60] = 1'b1;
        var_t[60]  = 9'h0F0;
        imp_ready  = 1'b0;
        d0 = done_cnt;
        x0 = xfer_cnt;
        start_pass(10'd60, 10'd2);
        wait_imp("rstpush");
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rstpush_imp_valid", 64'(imp_valid), 64'd0);
        check_val("rstpush_busy", 64'(busy), 64'd0);
        check_val("rstpush_done", 64'(done), 64'd0);
        tick();
        tick();
        reset_n   = 1'b1;
        imp_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check_val("rstpush_no_done", 64'(done_cnt - d0), 64'd0);
        check_val("rstpush_no_xfer", 64'(xfer_cnt - x0), 64'd0);
        check_val("rstpush_idle", 64'(busy), 64'd0);
        $display("[TB] reset during push: busy=%0d imp_valid=%0d", busy, imp_valid);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
